// File: rtl/jump_pc_unit_if.sv
// rtl/jump_pc_unit_if.sv - jump-register forwarding/stall handshake between the jump PC unit and the forwarding unit
interface jump_pc_unit_if;
   logic [4:0] RegJump;
   logic       jr_in_id;
   logic [1:0] ForwardJ;
   logic       stallJ;

   modport master (
      output RegJump,
      output jr_in_id,
      input  ForwardJ,
      input  stallJ
   );

   modport slave (
      input  RegJump,
      input  jr_in_id,
      output ForwardJ,
      output stallJ
   );
endinterface

// File: rtl/jump_pc_unit.sv
// rtl/jump_pc_unit.sv - PC register, IF/ID latch and J/JAL/JR/JALR resolution in decode
// Redirects fetch with a one-bubble flush, under cache freeze, load-use hold and jump-register stall.
module jump_pc_unit #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = 32'h00000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ICache_stall,
   input  logic             DCache_stall,
   input  logic             hazard_stall,
   input  logic [31:0]      IF_Instr,
   output logic [PC_W-1:0]  PC,
   output logic [31:0]      IFID_Instr,
   output logic [PC_W-1:0]  IFID_PC4,
   jump_pc_unit_if.master   jumpFwd,
   input  logic [PC_W-1:0]  RF_ReadData1,
   input  logic [PC_W-1:0]  EXMEM_ALUOut,
   input  logic [PC_W-1:0]  MEMWB_WriteData,
   input  logic             Branch_taken,
   input  logic [PC_W-1:0]  Branch_target,
   output logic             IF_flush,
   output logic [15:0]      jr_stall_cnt
);

   typedef enum logic {RUN, JWAIT} state_t;
   state_t state;

   logic [5:0]      opcode;
   logic [5:0]      funct;
   logic            isJ, isJal, isJr, isJalr;
   logic            jrInId, jumpInId;
   logic            freeze, jrHold, hold, redirect;
   logic [PC_W-1:0] pcPlus4, jTarget, jrTarget, redirectTarget;
   logic [15:0]     cntInc;

   assign opcode = IFID_Instr[31:26];
   assign funct  = IFID_Instr[5:0];
   assign isJ    = (opcode == 6'b000010);
   assign isJal  = (opcode == 6'b000011);
   assign isJr   = (opcode == 6'b000000) && (funct == 6'b001000);
   assign isJalr = (opcode == 6'b000000) && (funct == 6'b001001);

   assign jrInId   = isJr | isJalr;
   assign jumpInId = isJ | isJal | jrInId;

   assign jumpFwd.RegJump  = IFID_Instr[25:21];
   assign jumpFwd.jr_in_id = jrInId;

   // stallJ only means something while a register jump sits in decode.
   assign freeze   = ICache_stall | DCache_stall;
   assign jrHold   = jrInId & jumpFwd.stallJ;
   assign hold     = hazard_stall | jrHold;
   assign redirect = !rst & !freeze & !hold & (jumpInId | Branch_taken);
   assign IF_flush = redirect;

   assign pcPlus4 = PC + PC_W'(4);
   assign jTarget = {IFID_PC4[PC_W-1:28], IFID_Instr[25:0], 2'b00};

   always_comb begin
      jrTarget = RF_ReadData1;
      case (jumpFwd.ForwardJ)
         2'b01:   jrTarget = EXMEM_ALUOut;
         2'b10:   jrTarget = MEMWB_WriteData;
         default: jrTarget = RF_ReadData1;
      endcase
   end

   // A jump in decode is older than the branch and wins over it.
   always_comb begin
      redirectTarget = Branch_target;
      if (isJ | isJal) begin
         redirectTarget = jTarget;
      end else if (jrInId) begin
         redirectTarget = jrTarget;
      end
   end

   assign cntInc = (jr_stall_cnt == 16'hFFFF) ? jr_stall_cnt : jr_stall_cnt + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         PC           <= RESET_PC;
         IFID_Instr   <= '0;
         IFID_PC4     <= '0;
         state        <= RUN;
         jr_stall_cnt <= '0;
      end else if (!freeze) begin
         if (redirect) begin
            PC         <= redirectTarget;
            IFID_Instr <= '0;
            IFID_PC4   <= '0;
         end else if (!hold) begin
            PC         <= pcPlus4;
            IFID_Instr <= IF_Instr;
            IFID_PC4   <= pcPlus4;
         end

         case (state)
            RUN: begin
               if (jrHold && !hazard_stall) begin
                  state        <= JWAIT;
                  jr_stall_cnt <= cntInc;
               end
            end
            JWAIT: begin
               if (jrHold) begin
                  jr_stall_cnt <= cntInc;
               end else begin
                  state <= RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jump_pc_unit.sv
// tb/tb_jump_pc_unit.sv - table-driven scoreboard bench for jump_pc_unit
module tb_jump_pc_unit;

   logic        clk;
   logic        rst;
   logic        ICache_stall, DCache_stall, hazard_stall;
   logic [31:0] IF_Instr;
   logic [31:0] PC, IFID_Instr, IFID_PC4;
   logic [31:0] RF_ReadData1, EXMEM_ALUOut, MEMWB_WriteData;
   logic        Branch_taken;
   logic [31:0] Branch_target;
   logic        IF_flush;
   logic [15:0] jr_stall_cnt;

   jump_pc_unit_if jif ();

   jump_pc_unit #(.PC_W(32), .RESET_PC(32'h00000000)) dut (
      .clk             (clk),
      .rst             (rst),
      .ICache_stall    (ICache_stall),
      .DCache_stall    (DCache_stall),
      .hazard_stall    (hazard_stall),
      .IF_Instr        (IF_Instr),
      .PC              (PC),
      .IFID_Instr      (IFID_Instr),
      .IFID_PC4        (IFID_PC4),
      .jumpFwd         (jif.master),
      .RF_ReadData1    (RF_ReadData1),
      .EXMEM_ALUOut    (EXMEM_ALUOut),
      .MEMWB_WriteData (MEMWB_WriteData),
      .Branch_taken    (Branch_taken),
      .Branch_target   (Branch_target),
      .IF_flush        (IF_flush),
      .jr_stall_cnt    (jr_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  ctl;
      logic [31:0] ifInstr;
      logic [1:0]  fj;
      logic [31:0] rf, ex, mw, brT;
      logic [7:0]  comb;
      logic [31:0] ePC, eInstr, ePC4;
      logic [15:0] eCnt;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] pc, instr, pc4;
      logic [15:0] cnt;
   } exp_t;

   localparam logic [5:0] R  = 6'b100000;
   localparam logic [5:0] IC = 6'b010000;
   localparam logic [5:0] DC = 6'b001000;
   localparam logic [5:0] HZ = 6'b000100;
   localparam logic [5:0] SJ = 6'b000010;
   localparam logic [5:0] BR = 6'b000001;
   localparam logic [7:0] NC = 8'h00;
   localparam logic [31:0] JR5 = 32'h00A00008;

   vec_t tbl[$];
   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [7:0] cb(input logic jr, input logic fl, input logic [4:0] rj);
      return {1'b1, jr, fl, rj};
   endfunction

   task automatic add(input logic [5:0] ctl, input logic [31:0] ifI, input logic [1:0] fj,
                      input logic [31:0] rf, input logic [31:0] ex, input logic [31:0] mw,
                      input logic [31:0] brT, input logic [7:0] comb, input logic [31:0] ePC,
                      input logic [31:0] eInstr, input logic [31:0] ePC4, input logic [15:0] eCnt);
      vec_t v;
      v.ctl = ctl; v.ifInstr = ifI; v.fj = fj; v.rf = rf; v.ex = ex; v.mw = mw; v.brT = brT;
      v.comb = comb; v.ePC = ePC; v.eInstr = eInstr; v.ePC4 = ePC4; v.eCnt = eCnt;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic step(input int idx, input vec_t v);
      exp_t e, got;
      @(negedge clk);
      rst           = v.ctl[5];
      ICache_stall  = v.ctl[4];
      DCache_stall  = v.ctl[3];
      hazard_stall  = v.ctl[2];
      jif.stallJ    = v.ctl[1];
      Branch_taken  = v.ctl[0];
      IF_Instr      = v.ifInstr;
      jif.ForwardJ  = v.fj;
      RF_ReadData1  = v.rf;
      EXMEM_ALUOut  = v.ex;
      MEMWB_WriteData = v.mw;
      Branch_target = v.brT;
      #1;
      if (v.comb[7]) begin
         check("jr_in_id", idx, {31'd0, jif.jr_in_id}, {31'd0, v.comb[6]});
         check("IF_flush", idx, {31'd0, IF_flush}, {31'd0, v.comb[5]});
         check("RegJump", idx, {27'd0, jif.RegJump}, {27'd0, v.comb[4:0]});
      end
      e.idx = idx; e.pc = v.ePC; e.instr = v.eInstr; e.pc4 = v.ePC4; e.cnt = v.eCnt;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard step %0d: got empty queue want entry", idx);
      end else begin
         got = expQ.pop_front();
         check("PC", got.idx, PC, got.pc);
         check("IFID_Instr", got.idx, IFID_Instr, got.instr);
         check("IFID_PC4", got.idx, IFID_PC4, got.pc4);
         check("jr_stall_cnt", got.idx, {16'd0, jr_stall_cnt}, {16'd0, got.cnt});
      end
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; ICache_stall = 0; DCache_stall = 0; hazard_stall = 0;
      IF_Instr = '0; RF_ReadData1 = '0; EXMEM_ALUOut = '0; MEMWB_WriteData = '0;
      Branch_taken = 0; Branch_target = '0; jif.ForwardJ = 2'b00; jif.stallJ = 1'b0;

      // ctl, IF_Instr, ForwardJ, RF, EXMEM, MEMWB, Branch_target, comb, PC, IFID_Instr, IFID_PC4, cnt
      add(R,     0,            0, 0,      0,     0,      0,            NC,            0,            0,            0,            0);
      add(0,     0,            0, 0,      0,     0,      0,            cb(0,0,0),     32'h4,        0,            32'h4,        0);
      add(0,     0,            0, 0,      0,     0,      0,            cb(0,0,0),     32'h8,        0,            32'h8,        0);
      add(0,     0,            0, 0,      0,     0,      0,            cb(0,0,0),     32'hC,        0,            32'hC,        0);
      add(BR,    0,            0, 0,      0,     0,      32'h100,      cb(0,1,0),     32'h100,      0,            0,            0);
      add(0,     32'h08000040, 0, 0,      0,     0,      0,            cb(0,0,0),     32'h104,      32'h08000040, 32'h104,      0);
      add(BR,    32'h24020005, 0, 0,      0,     0,      32'h999,      cb(0,1,0),     32'h100,      0,            0,            0);
      add(0,     JR5,          0, 0,      0,     0,      0,            cb(0,0,0),     32'h104,      JR5,          32'h104,      0);
      add(0,     32'h24020005, 1, 32'h5555, 32'h200, 32'h7777, 0,      cb(1,1,5),     32'h200,      0,            0,            0);
      add(SJ,    JR5,          0, 0,      0,     0,      0,            cb(0,0,0),     32'h204,      JR5,          32'h204,      0);
      add(SJ,    32'h24020005, 0, 32'h5555, 32'h200, 32'h7777, 0,      cb(1,0,5),     32'h204,      JR5,          32'h204,      1);
      add(SJ,    32'h24020005, 0, 32'h5555, 32'h200, 32'h7777, 0,      cb(1,0,5),     32'h204,      JR5,          32'h204,      2);
      add(0,     32'h24020005, 2, 32'h5555, 32'h200, 32'h3000, 0,      cb(1,1,5),     32'h3000,     0,            0,            2);
      add(0,     0,            0, 0,      0,     0,      0,            cb(0,0,0),     32'h3004,     0,            32'h3004,     2);
      add(HZ|BR, 32'h12345678, 0, 0,      0,     0,      32'h500,      cb(0,0,0),     32'h3004,     0,            32'h3004,     2);
      add(0,     32'h0C000800, 0, 0,      0,     0,      0,            cb(0,0,0),     32'h3008,     32'h0C000800, 32'h3008,     2);
      add(IC,    32'hDEADBEEF, 0, 0,      0,     0,      0,            cb(0,0,0),     32'h3008,     32'h0C000800, 32'h3008,     2);
      add(DC,    32'hDEADBEEF, 0, 0,      0,     0,      0,            cb(0,0,0),     32'h3008,     32'h0C000800, 32'h3008,     2);
      add(IC|DC, 32'hDEADBEEF, 0, 0,      0,     0,      0,            cb(0,0,0),     32'h3008,     32'h0C000800, 32'h3008,     2);
      add(0,     32'hDEADBEEF, 0, 0,      0,     0,      0,            cb(0,1,0),     32'h2000,     0,            0,            2);
      add(0,     32'h00E0F809, 0, 0,      0,     0,      0,            cb(0,0,0),     32'h2004,     32'h00E0F809, 32'h2004,     2);
      add(0,     32'h24020005, 3, 32'h440, 32'h200, 32'h3000, 0,       cb(1,1,7),     32'h440,      0,            0,            2);
      add(BR,    0,            0, 0,      0,     0,      32'h3C,       cb(0,1,0),     32'h3C,       0,            0,            2);
      add(0,     JR5,          0, 0,      0,     0,      0,            cb(0,0,0),     32'h40,       JR5,          32'h40,       2);
      add(SJ,    32'h24020005, 0, 32'h5555, 0,   0,      0,            cb(1,0,5),     32'h40,       JR5,          32'h40,       3);
      add(SJ|IC, 32'h24020005, 0, 32'h5555, 0,   0,      0,            cb(1,0,5),     32'h40,       JR5,          32'h40,       3);
      add(SJ|HZ, 32'h24020005, 0, 32'h5555, 0,   0,      0,            cb(1,0,5),     32'h40,       JR5,          32'h40,       4);
      add(R|SJ,  32'h24020005, 0, 32'h5555, 0,   0,      0,            cb(1,0,5),     0,            0,            0,            0);
      add(SJ,    0,            0, 0,      0,     0,      0,            cb(0,0,0),     32'h4,        0,            32'h4,        0);
      add(BR,    0,            0, 0,      0,     0,      32'hFFFFFFF8, cb(0,1,0),     32'hFFFFFFF8, 0,            0,            0);
      add(0,     0,            0, 0,      0,     0,      0,            cb(0,0,0),     32'hFFFFFFFC, 0,            32'hFFFFFFFC, 0);
      add(0,     0,            0, 0,      0,     0,      0,            cb(0,0,0),     0,            0,            0,            0);
      add(BR,    0,            0, 0,      0,     0,      32'h80,       cb(0,1,0),     32'h80,       0,            0,            0);
      add(R|IC,  0,            0, 0,      0,     0,      0,            NC,            0,            0,            0,            0);
      add(0,     JR5,          0, 0,      0,     0,      0,            cb(0,0,0),     32'h4,        JR5,          32'h4,        0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(i, tbl[i]);
      end

      // Long JR operand stall: counter climbs once per edge, PC pinned, then redirect via EX/MEM.
      for (int k = 1; k <= 5; k++) begin
         v.ctl = SJ; v.ifInstr = 32'h24020005; v.fj = 2'b01; v.rf = 32'h5555;
         v.ex = 32'h600; v.mw = 32'h7777; v.brT = 0; v.comb = cb(1, 0, 5);
         v.ePC = 32'h4; v.eInstr = JR5; v.ePC4 = 32'h4; v.eCnt = 16'(k);
         step(100 + k, v);
      end
      v.ctl = 0; v.comb = cb(1, 1, 5);
      v.ePC = 32'h600; v.eInstr = 0; v.ePC4 = 0; v.eCnt = 16'd5;
      step(106, v);
      v.ctl = 0; v.ifInstr = 0; v.comb = cb(0, 0, 0);
      v.ePC = 32'h604; v.eInstr = 0; v.ePC4 = 32'h604; v.eCnt = 16'd5;
      step(107, v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
